regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Owns the single register-file write port and shares it between two requesters:
- the in-order pipeline writeback (WB);
- the long-latency unit (LLU, mul/div), which completes out of order.

It buffers LLU results, tracks which registers have LLU writes outstanding (scoreboard), and drives the decode-stage stall. It sits between MEM/WB plus the LLU and the register file, feeding its write-enable, address and data inputs.

Parameters:
- DATA_W, 64, writeback data width; the register file stores the low 32 bits.
- FIFO_DEPTH, 2, LLU result buffer entries; power of 2, at least 2.
- STARVE_LIMIT, 4, number of consecutive cycles a non-empty LLU FIFO may lose to WB before the block forces a WB hold.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- wb_valid, in, 1, pipeline writeback request (MEM/WB RegWrite).
- wb_dst, in, 5, WB destination register.
- wb_data, in, DATA_W, WB data.
- wb_link, in, 1, jump-and-link; forces the destination to r31.
- wb_hold, out, 1, requests the pipeline to suppress wb_valid next cycle (starvation relief).
- llu_valid, in, 1, LLU result valid.
- llu_ready, out, 1, FIFO not full; a transfer occurs when llu_valid and llu_ready are both high.
- llu_dst, in, 5, LLU destination register.
- llu_data, in, DATA_W, LLU result.
- issue_valid, in, 1, LLU operation issued this cycle.
- issue_rd, in, 5, destination register of the issued operation.
- id_rs, in, 5, decode-stage source register.
- id_rt, in, 5, decode-stage source register.
- id_rd, in, 5, decode-stage register operand.
- id_stall, out, 1, high if any of id_rs/id_rt/id_rd is marked busy (combinational from busy_mask).
- rf_we, out, 1, register-file write enable (registered).
- rf_waddr, out, 5, register-file write address (registered).
- rf_wdata, out, DATA_W, register-file write data (registered).
- busy_mask, out, 32, scoreboard; bit n high means an LLU write to rn is outstanding.

Behaviour:
Reset:
- rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, FIFO empty, starve_cnt=0, wb_hold=0.
- llu_ready=1 in the first cycle after reset.
- Reset mid-operation discards buffered LLU results and clears the scoreboard.

Grant (each cycle, one winner):
- WB wins if wb_valid is high.
- Otherwise the FIFO head wins if the FIFO is non-empty.
- Otherwise idle: rf_we=0 next cycle.
- The winner's write appears on rf_* one cycle after the request (1-cycle latency).

Write addressing:
- WB destination = 31 if wb_link, else wb_dst.
- Any write resolving to r0 gives rf_we=0, but the grant is still consumed (a FIFO pop still happens).
- rf_wdata carries the full DATA_W value.

FIFO:
- Push on an llu_valid && llu_ready handshake.
- Pop when the head is granted.
- Push and pop in the same cycle on a full FIFO is not allowed, because llu_ready is low when full.
- A push into an empty FIFO cannot be granted in the same cycle: the write is at least 1 cycle after the push, 2 cycles after the handshake.

Starvation (states NORMAL / HOLD):
- starve_cnt increments each cycle the FIFO is non-empty and WB wins.
- starve_cnt resets to 0 when the head is granted or the FIFO is empty.
- When starve_cnt reaches STARVE_LIMIT, go to HOLD: wb_hold=1 for exactly one cycle, then return to NORMAL.
- If wb_valid is still high during HOLD, WB still wins and starve_cnt saturates at STARVE_LIMIT, re-issuing wb_hold next cycle.

Scoreboard:
- issue_valid with issue_rd≠0 sets busy[issue_rd].
- A committed LLU write clears busy[dst].
- Same-cycle set and clear of the same register: set wins.
- A WB write never alters busy_mask.
- Issue to a busy register is illegal; id_stall prevents it.
- busy[0] is always 0.

Optional Feature:
REGFILE_ARB_PERF_EN:
- With the macro: adds outputs perf_llu_writes (32-bit), perf_wb_conflicts (32-bit, cycles where WB won over a non-empty FIFO) and perf_holds (16-bit). All counters wrap, are cleared by rst, and update on the rising edge.
- Without the macro: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds REG_ADDR_W=5, LINK_REG=5'd31, ZERO_REG=5'd0, and the arb_state_t enum {ARB_NORMAL, ARB_HOLD}.
- One natural sub-module: regfile_wr_fifo, a parameterised DEPTH x (5+DATA_W) synchronous FIFO with valid/ready push and a pop strobe.

Test Plan:
- Reset, then wb_valid=1, wb_dst=8, wb_data=0x1234 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x1234; busy_mask=0.
- wb_valid=1, wb_link=1, wb_dst=3, data=0x400 -> rf_waddr=31, rf_wdata=0x400. Then wb_dst=0 with no link -> rf_we=0.
- issue_valid, issue_rd=10; next cycle id_rs=10 -> id_stall=1. LLU handshake dst=10, data=0x77 with WB idle -> rf write r10=0x77 two cycles after the handshake; busy[10]=0 and id_stall=0 the cycle after the write.
- Fill the FIFO with 2 results while wb_valid is held high -> llu_ready=0. After 4 WB wins, wb_hold=1 for one cycle. Drop wb_valid -> FIFO head written; llu_ready returns to 1.
- Same cycle: issue_rd=12 and a committing LLU write to r12 -> busy[12] stays 1.
- Assert rst with the FIFO holding 1 entry and busy_mask=0x400 -> next cycle busy_mask=0, rf_we=0, llu_ready=1; the buffered result is never written.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: register addressing
// constants and the starvation-relief state encoding.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] LINK_REG = 5'd31;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_HOLD   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Small synchronous FIFO buffering LLU results; valid/ready push, pop strobe,
// head entry visible combinationally so it can compete for the write port.
module regfile_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             full;
  logic             push_fire;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ready = !full;
  assign push_fire  = push_valid && !full;
  assign head_data  = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between pipeline writeback and
// buffered LLU results, with scoreboard and starvation relief.
// Optional performance counters: define REGFILE_ARB_PERF_EN.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dst,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  wb_link,
  output logic                  wb_hold,
  input  logic                  llu_valid,
  output logic                  llu_ready,
  input  logic [REG_ADDR_W-1:0] llu_dst,
  input  logic [DATA_W-1:0]     llu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  id_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [31:0]           busy_mask
`ifdef REGFILE_ARB_PERF_EN
  ,
  output logic [31:0]           perf_llu_writes,
  output logic [31:0]           perf_wb_conflicts,
  output logic [15:0]           perf_holds
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                  fifo_empty;
  logic [REG_ADDR_W-1:0] head_dst;
  logic [DATA_W-1:0]     head_data;
  logic                  grant_wb;
  logic                  grant_llu;
  logic                  llu_clear;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [31:0]           busy_reg;
  logic [31:0]           busy_next;
  logic [SW-1:0]         starve_cnt_reg;
  logic [SW-1:0]         starve_cnt_next;
  arb_state_t            state_reg;
  arb_state_t            state_next;

  regfile_wr_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(REG_ADDR_W + DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_valid(llu_valid),
    .push_ready(llu_ready),
    .push_data ({llu_dst, llu_data}),
    .pop       (grant_llu),
    .head_data ({head_dst, head_data}),
    .empty     (fifo_empty)
  );

  assign grant_wb  = wb_valid;
  assign grant_llu = !wb_valid && !fifo_empty;
  assign wb_dest   = wb_link ? LINK_REG : wb_dst;
  assign llu_clear = grant_llu && (head_dst != ZERO_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant_wb) begin
      rf_we    <= (wb_dest != ZERO_REG);
      rf_waddr <= wb_dest;
      rf_wdata <= wb_data;
    end else if (grant_llu) begin
      rf_we    <= (head_dst != ZERO_REG);
      rf_waddr <= head_dst;
      rf_wdata <= head_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Scoreboard: a new issue overrides a same-cycle commit to the same register.
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    assign busy_next[gi] = (issue_valid && (issue_rd == REG_ADDR_W'(gi))) ||
                           (busy_reg[gi] && !(llu_clear && (head_dst == REG_ADDR_W'(gi))));
  end

  always_ff @(posedge clk) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end

  assign busy_mask = busy_reg;
  assign id_stall  = busy_reg[id_rs] || busy_reg[id_rt] || busy_reg[id_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB_NORMAL;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Counter saturates so a pipeline that ignores wb_hold keeps seeing it.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    state_next      = ARB_NORMAL;
    if (fifo_empty || grant_llu) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != SW'(STARVE_LIMIT)) begin
      starve_cnt_next = starve_cnt_reg + SW'(1);
    end
    if (starve_cnt_next == SW'(STARVE_LIMIT)) state_next = ARB_HOLD;
  end

  assign wb_hold = (state_reg == ARB_HOLD);

`ifdef REGFILE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_llu_writes   <= '0;
      perf_wb_conflicts <= '0;
      perf_holds        <= '0;
    end else begin
      if (grant_llu) perf_llu_writes <= perf_llu_writes + 32'd1;
      if (grant_wb && !fifo_empty) perf_wb_conflicts <= perf_wb_conflicts + 32'd1;
      if (state_next == ARB_HOLD) perf_holds <= perf_holds + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [63:0] wb_data;
  logic        wb_link;
  logic        wb_hold;
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_dst;
  logic [63:0] llu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] busy_mask;

  int test_count = 0;
  int fail_count = 0;

  regfile_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .wb_link    (wb_link),
    .wb_hold    (wb_hold),
    .llu_valid  (llu_valid),
    .llu_ready  (llu_ready),
    .llu_dst    (llu_dst),
    .llu_data   (llu_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_stall   (id_stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy_mask  (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_value(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end else begin
      $display("[TB] %s ok (0x%0h)", tag, actual);
    end
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_dst = '0; wb_data = '0; wb_link = 1'b0;
    llu_valid = 1'b0; llu_dst = '0; llu_data = '0; issue_valid = 1'b0;
    issue_rd = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    tick(); tick();
    rst = 1'b0;
    check_value("reset_rf_we", rf_we, 0);
    check_value("reset_rf_waddr", rf_waddr, 0);
    check_value("reset_rf_wdata", rf_wdata, 0);
    check_value("reset_busy", busy_mask, 0);
    check_value("reset_hold", wb_hold, 0);
    check_value("reset_llu_ready", llu_ready, 1);

    // Plain writeback
    wb_valid = 1'b1; wb_dst = 5'd8; wb_data = 64'h1234;
    tick();
    check_value("wb_we", rf_we, 1);
    check_value("wb_waddr", rf_waddr, 8);
    check_value("wb_wdata", rf_wdata, 64'h1234);
    check_value("wb_busy", busy_mask, 0);

    // Jump-and-link forces r31
    wb_link = 1'b1; wb_dst = 5'd3; wb_data = 64'h400;
    tick();
    check_value("link_we", rf_we, 1);
    check_value("link_waddr", rf_waddr, 31);
    check_value("link_wdata", rf_wdata, 64'h400);

    // Write to r0 suppressed, then idle
    wb_link = 1'b0; wb_dst = 5'd0; wb_data = 64'h55;
    tick();
    check_value("r0_we", rf_we, 0);
    wb_valid = 1'b0;
    tick();
    check_value("idle_we", rf_we, 0);

    // Scoreboard set, LLU writeback, clear
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    issue_valid = 1'b0;
    check_value("issue_busy", busy_mask, 32'h400);
    id_rs = 5'd10;
    #1;
    check_value("issue_stall", id_stall, 1);
    llu_valid = 1'b1; llu_dst = 5'd10; llu_data = 64'h77;
    tick();
    llu_valid = 1'b0;
    check_value("llu_push_no_write", rf_we, 0);
    tick();
    check_value("llu_we", rf_we, 1);
    check_value("llu_waddr", rf_waddr, 10);
    check_value("llu_wdata", rf_wdata, 64'h77);
    tick();
    check_value("llu_busy_clear", busy_mask, 0);
    check_value("llu_stall_clear", id_stall, 0);
    check_value("llu_idle_we", rf_we, 0);
    id_rs = 5'd0;

    // Starvation: WB held high while FIFO fills
    wb_valid = 1'b1; wb_dst = 5'd5; wb_data = 64'h101;
    llu_valid = 1'b1; llu_dst = 5'd20; llu_data = 64'hA1;
    tick();
    check_value("starve_ready_1", llu_ready, 1);
    llu_dst = 5'd21; llu_data = 64'hA2; wb_data = 64'h102;
    tick();
    llu_valid = 1'b0;
    check_value("starve_full", llu_ready, 0);
    check_value("starve_wb_waddr", rf_waddr, 5);
    check_value("starve_wb_wdata", rf_wdata, 64'h102);
    tick();
    tick();
    check_value("starve_hold_3", wb_hold, 0);
    tick();
    check_value("starve_hold_4", wb_hold, 1);
    wb_valid = 1'b0;
    tick();
    check_value("starve_hold_off", wb_hold, 0);
    check_value("starve_head_we", rf_we, 1);
    check_value("starve_head_waddr", rf_waddr, 20);
    check_value("starve_head_wdata", rf_wdata, 64'hA1);
    check_value("starve_ready_back", llu_ready, 1);
    tick();
    check_value("starve_second_waddr", rf_waddr, 21);
    check_value("starve_second_wdata", rf_wdata, 64'hA2);
    tick();
    check_value("starve_drained_we", rf_we, 0);

    // Same-cycle set and clear of r12: set wins
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    llu_valid = 1'b1; llu_dst = 5'd12; llu_data = 64'hC;
    tick();
    llu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    check_value("setwin_waddr", rf_waddr, 12);
    check_value("setwin_busy", busy_mask, 32'h1000);
    llu_valid = 1'b1; llu_dst = 5'd12; llu_data = 64'hD;
    tick();
    llu_valid = 1'b0;
    tick();
    check_value("setwin_cleared", busy_mask, 0);

    // Reset with one buffered result
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    issue_valid = 1'b0;
    check_value("rst_pre_busy", busy_mask, 32'h400);
    wb_valid = 1'b1; wb_dst = 5'd7; wb_data = 64'h9;
    llu_valid = 1'b1; llu_dst = 5'd10; llu_data = 64'hDEAD;
    tick();
    wb_valid = 1'b0; llu_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_value("rst_mid_busy", busy_mask, 0);
    check_value("rst_mid_we", rf_we, 0);
    check_value("rst_mid_ready", llu_ready, 1);
    tick();
    check_value("rst_discard_1", rf_we, 0);
    tick();
    check_value("rst_discard_2", rf_we, 0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
